// File: rtl/axi_stream_mux_arbiter_8.sv
// axi_stream_mux_arbiter_8: packet-aware round-robin arbiter driving the select of an 8:1 registered AXI stream mux
module axi_stream_mux_arbiter_8 #(
    parameter int N_INPUTS     = 8,
    parameter int MAX_BURST    = 16,
    parameter int SWITCH_DELAY = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_INPUTS-1:0] request,
    input  logic                out_valid,
    input  logic                out_ready,
    input  logic                out_tlast,
    output logic [2:0]          address,
    output logic [N_INPUTS-1:0] grant,
    output logic                busy,
    output logic                forced_release
);
    localparam int BW = MAX_BURST > 0 ? $clog2(MAX_BURST + 1) : 1;
    localparam int IW = IDLE_TIMEOUT > 0 ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam int SW = SWITCH_DELAY > 1 ? $clog2(SWITCH_DELAY) : 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SWITCH = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    logic [1:0]    state;
    logic [2:0]    last_grant;
    logic [2:0]    winner;
    logic [BW-1:0] beat_cnt;
    logic [IW-1:0] idle_cnt;
    logic [SW-1:0] settle_cnt;
    logic          beat;
    logic          rel_last;
    logic          rel_burst;
    logic          rel_idle;
    logic          release_now;

    assign busy        = state != IDLE;
    assign beat        = state == ACTIVE && out_valid && out_ready;
    assign rel_last    = beat && out_tlast;
    assign rel_burst   = MAX_BURST != 0 && beat && beat_cnt == BW'(MAX_BURST - 1);
    assign rel_idle    = IDLE_TIMEOUT != 0 && state == ACTIVE && !beat && idle_cnt == IW'(IDLE_TIMEOUT - 1);
    assign release_now = rel_last || rel_burst || rel_idle;

    // search starts just past the previous winner, so the last winner comes last
    always_comb begin
        logic       found;
        logic [2:0] idx;
        winner = last_grant;
        found  = 1'b0;
        for (int i = 0; i < N_INPUTS; i++) begin
            idx = last_grant + 3'(i) + 3'd1;
            if (!found && request[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            address        <= '0;
            grant          <= '0;
            forced_release <= 1'b0;
            last_grant     <= 3'd7;
            beat_cnt       <= '0;
            idle_cnt       <= '0;
            settle_cnt     <= '0;
        end else begin
            forced_release <= 1'b0;
            if (state == IDLE) begin
                if (enable && |request) begin
                    state      <= SWITCH;
                    address    <= winner;
                    grant      <= N_INPUTS'(1) << winner;
                    last_grant <= winner;
                    settle_cnt <= SW'(SWITCH_DELAY - 1);
                end
            end else if (state == SWITCH) begin
                if (settle_cnt == '0) begin
                    state    <= ACTIVE;
                    beat_cnt <= '0;
                    idle_cnt <= '0;
                end else begin
                    settle_cnt <= settle_cnt - SW'(1);
                end
            end else if (state == ACTIVE) begin
                if (release_now) begin
                    state          <= IDLE;
                    grant          <= '0;
                    forced_release <= !rel_last;
                end else if (beat) begin
                    beat_cnt <= beat_cnt + BW'(1);
                    idle_cnt <= '0;
                end else if (!(&idle_cnt)) begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule
